micro_frame_accum: RTL

- Downstream consumer of the registered 4-bit nibble stream produced by the micro lookup stage.
- Accepts one nibble per cycle over a valid/ready handshake and accumulates FRAME samples into a sum and a running maximum.
- Presents the frame result on a held valid/ready output port; stalls input until the result is taken.
- Used as a sequential micro benchmark: FSM, counter, accumulator and backpressure.

---
 rtl/micro_accum_pkg.sv | 28 ++
 rtl/micro_frame_accum.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/micro_accum_pkg.sv
// ----------------------------------------------------------------------------
// micro_accum_pkg
//   Shared definitions for the micro frame accumulator: default parameter
//   values, the two-state FSM encoding and an unsigned max helper sized for
//   BITS-wide samples.
// ----------------------------------------------------------------------------
package micro_accum_pkg;

  // Default geometry: four 4-bit samples per frame.
  // SUM_BITS = BITS + CNT_BITS, so the frame sum cannot wrap.
  localparam int BITS     = 4;
  localparam int FRAME    = 4;
  localparam int CNT_BITS = 2;
  localparam int SUM_BITS = 6;

  // ACCUM collects samples. HOLD presents a finished frame until it is taken.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Unsigned maximum of two samples.
  function automatic logic [BITS-1:0] max_val(input logic [BITS-1:0] a,
                                              input logic [BITS-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage : micro_accum_pkg

// File: rtl/micro_frame_accum.sv
// ----------------------------------------------------------------------------
// micro_frame_accum
//   Accepts one unsigned sample per cycle over a valid/ready handshake. It
//   accumulates FRAME samples into a sum and a running maximum. It then holds
//   the frame result on a valid/ready output until the consumer takes it.
//   Input is stalled (in_ready=0) for as long as a result is being held.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   in_data carries a sample
//   in_data    sample value, unsigned, BITS wide
//   in_ready   block accepts a sample this cycle (combinational from state)
//   out_valid  frame result available (registered)
//   out_ready  consumer takes the result this cycle
//   out_sum    sum of the FRAME samples, modulo 2^SUM_BITS
//   out_max    largest sample in the frame
//
// Timing
//   The result is valid 1 cycle after the last sample is accepted.
//   With in_valid and out_ready held high, one frame completes every
//   FRAME+1 cycles.
// ----------------------------------------------------------------------------
module micro_frame_accum #(
  parameter int BITS     = micro_accum_pkg::BITS,
  parameter int FRAME    = micro_accum_pkg::FRAME,
  parameter int CNT_BITS = micro_accum_pkg::CNT_BITS,
  parameter int SUM_BITS = micro_accum_pkg::SUM_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [BITS-1:0]     in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SUM_BITS-1:0] out_sum,
  output logic [BITS-1:0]     out_max
);

  import micro_accum_pkg::*;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                state_q,   state_d;
  logic [CNT_BITS-1:0]   count_q,   count_d;
  logic [SUM_BITS-1:0]   acc_sum_q, acc_sum_d;
  logic [BITS-1:0]       acc_max_q, acc_max_d;
  logic [SUM_BITS-1:0]   out_sum_q, out_sum_d;
  logic [BITS-1:0]       out_max_q, out_max_d;

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  logic                  accept;
  logic                  last_sample;
  logic [SUM_BITS-1:0]   sum_next;
  logic [BITS-1:0]       max_next;

  // in_ready depends only on state. It never looks at out_ready. A HOLD-state
  // handshake therefore cannot admit a sample in the same cycle.
  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == HOLD);
  assign out_sum     = out_sum_q;
  assign out_max     = out_max_q;

  assign accept      = in_valid & in_ready;
  assign last_sample = (count_q == CNT_BITS'(FRAME - 1));
  assign sum_next    = acc_sum_q + SUM_BITS'(in_data);
  assign max_next    = max_val(acc_max_q, in_data);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal this block drives is given a hold value first. No
    // path can leave one unassigned, so no latch is inferred.
    state_d   = state_q;
    count_d   = count_q;
    acc_sum_d = acc_sum_q;
    acc_max_d = acc_max_q;
    out_sum_d = out_sum_q;
    out_max_d = out_max_q;

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (last_sample) begin
            // The final sample goes straight into the result registers.
            // The accumulators clear at the same time, so the next frame
            // starts at zero.
            out_sum_d = sum_next;
            out_max_d = max_next;
            acc_sum_d = '0;
            acc_max_d = '0;
            count_d   = '0;
            state_d   = HOLD;
          end else begin
            acc_sum_d = sum_next;
            acc_max_d = max_next;
            count_d   = count_q + CNT_BITS'(1);
          end
        end
      end

      HOLD: begin
        // The result registers keep their value after the handshake.
        // They are simply ignored while out_valid is low.
        if (out_ready) begin
          state_d = ACCUM;
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: all registers, including the result registers, are reset.
  // A reset therefore drops out_valid at once, discards any partial frame and
  // leaves no X on out_sum/out_max.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments. Every flop samples the pre-edge
      // values computed above, whatever order these statements appear in.
      state_q   <= ACCUM;
      count_q   <= '0;
      acc_sum_q <= '0;
      acc_max_q <= '0;
      out_sum_q <= '0;
      out_max_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_sum_q <= acc_sum_d;
      acc_max_q <= acc_max_d;
      out_sum_q <= out_sum_d;
      out_max_q <= out_max_d;
    end
  end

endmodule : micro_frame_accum
